// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle between the command-driven master and a memory-mapped slave.
// The master modport drives address/data/valid and the response readies; the slave modport mirrors it.
interface axi_lite_master_if #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI transaction and one
// response, with a per-phase wait counter that reports a timeout and then drains the slave.
module axi_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 40,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [2:0]                      dbg_state_o,
    axi_lite_master_if.master               m_axi
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and payload is held stable from valid until that edge.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5,
        DRAIN   = 3'd6
    } state_e;

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic            is_write_q, is_write_d;
    logic            xact_open_q, xact_open_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic            bready_q, bready_d;
    logic            rready_q, rready_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            go_timeout;
    logic            b_hs, r_hs, timeout_hit;

    assign b_hs        = bready_q && m_axi.bvalid;
    assign r_hs        = rready_q && m_axi.rvalid;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            is_write_q    <= 1'b0;
            xact_open_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            is_write_q    <= is_write_d;
            xact_open_q   <= xact_open_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        is_write_d    = is_write_q;
        xact_open_d   = xact_open_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = '0;
        go_timeout    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    is_write_d  = cmd_write;
                    xact_open_d = 1'b1;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                // AW and W retire independently; the phase ends when both have.
                awvalid_d = awvalid_q && !m_axi.awready;
                wvalid_d  = wvalid_q && !m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (timeout_hit) begin
                    go_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi.bresp;
                    rsp_timeout_d = 1'b0;
                    bready_d      = 1'b0;
                    xact_open_d   = 1'b0;
                    state_d       = RSP;
                end else if (timeout_hit) begin
                    go_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RD_ADDR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (timeout_hit) begin
                    go_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi.rdata;
                    rsp_resp_d    = m_axi.rresp;
                    rsp_timeout_d = 1'b0;
                    rready_d      = 1'b0;
                    xact_open_d   = 1'b0;
                    state_d       = RSP;
                end else if (timeout_hit) begin
                    go_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                // Finish the abandoned transaction silently while the timeout response waits.
                awvalid_d   = awvalid_q && !m_axi.awready;
                wvalid_d    = wvalid_q && !m_axi.wready;
                arvalid_d   = arvalid_q && !m_axi.arready;
                xact_open_d = xact_open_q && !b_hs && !r_hs;
                bready_d    = xact_open_d && is_write_q && !awvalid_d && !wvalid_d;
                rready_d    = xact_open_d && !is_write_q && !arvalid_d;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                if (!xact_open_d && !rsp_valid_d) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_timeout) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
            state_d       = DRAIN;
        end

        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign dbg_state_o   = state_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 40, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, max wait cycles per transaction phase; range 2..65535.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 Clock and reset ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  synchronous reset, active low.
REQ-006 Command ports:
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both high.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
REQ-007 Response ports:
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both high.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction timed out.
REQ-008 AXI4-Lite master ports M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY; standard directions and widths; AWPROT=ARPROT=3'b000.

Function
REQ-009 FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP, DRAIN.
REQ-010 cmd_ready SHALL be 1 only in IDLE; command fields are registered on accept, and commands arriving outside IDLE are left pending.
REQ-011 Write accept: IDLE->WR_ADDR; AWVALID and WVALID SHALL both rise the next cycle.
REQ-012 In WR_ADDR each of AWVALID and WVALID SHALL drop independently after its own handshake; when both channels are done (same or different cycles), go to WR_RESP with BREADY=1.
REQ-013 Read accept: IDLE->RD_ADDR with ARVALID=1; on ARREADY go to RD_DATA with RREADY=1.
REQ-014 On BVALID in WR_RESP, or RVALID in RD_DATA, capture BRESP/RRESP (and RDATA for reads) into the response registers, then go to RSP.
REQ-015 In RSP, rsp_valid=1 and rsp_* held stable until rsp_ready; then go to IDLE. Back-to-back commands SHALL have a minimum of 4 cycles from cmd accept to rsp_valid with zero-wait slave.
REQ-016 VALID signals SHALL NOT depend combinationally on READY; once asserted, address/data/strobes SHALL stay stable until the handshake.
REQ-017 A 16-bit wait counter SHALL clear on entry to WR_ADDR, WR_RESP, RD_ADDR and RD_DATA, and increment each cycle spent in them.
REQ-018 When the counter reaches TIMEOUT_CYCLES-1 without completing the current phase, the block SHALL present a response with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0, and enter DRAIN.
REQ-019 DRAIN SHALL keep outstanding VALIDs asserted and BREADY/RREADY high until the transaction completes; no second response SHALL be emitted.
REQ-020 DRAIN exits to IDLE only after the slave completes and the timeout response has been consumed; while in DRAIN, rsp_valid follows REQ-015.
REQ-021 BVALID or RVALID arriving in any state other than its waiting state SHALL be ignored (protocol error, no side effect).
REQ-022 rsp_timeout SHALL be 0 for normal completions; SLVERR/DECERR from the slave SHALL pass through on rsp_resp.

Reset
REQ-023 While M_AXI_ARESETN=0 at a clock edge: state=IDLE, all *VALID=0, BREADY=RREADY=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, counter=0.
REQ-024 cmd_ready SHALL be 1 on the first cycle after reset release.
REQ-025 Reset mid-transaction SHALL abandon it without a response; the slave is reset by the same signal.

Verification
REQ-026 Write 0x8 data 0x12345678 strb 0xF, zero-wait slave -> AW/W valid together one cycle, rsp_valid with resp 00, timeout 0.
REQ-027 Write where AWREADY is 3 cycles after WREADY -> WVALID drops after its handshake; AWVALID is held with stable address; exactly one response.
REQ-028 Read 0x0 from the register-file slave -> rsp_rdata=0xDEADBEEF, resp 00; read 0x4 -> 0x76543210.
REQ-029 TIMEOUT_CYCLES=16, slave never asserts ARREADY -> rsp at cycle 16 with timeout=1, resp 10, rdata 0; late ARREADY+RVALID drained; no second rsp; then IDLE.
REQ-030 rsp_ready held low 10 cycles -> rsp fields stable; cmd_ready stays 0 until consumed.
REQ-031 Reset asserted while in WR_RESP -> next cycle all outputs at reset values; new read then completes normally.
